// File: rtl/warn_scan_pkg.sv
// Shared types for the warning-count change scanner: FSM states, count width
// and the {channel, count} event record width.
package warn_scan_pkg;
  typedef enum logic [1:0] {IDLE, SNAP, SCAN, DONE} scan_state_e;

  localparam int CNT_W = 16;

  function automatic int evt_w(input int ch_w);
    return ch_w + CNT_W;
  endfunction
endpackage

// File: rtl/warn_cnt_scan_if.sv
// Event stream from the scanner: show-ahead FIFO head with valid/ready.
interface warn_cnt_scan_if #(parameter int CH_W = 8);
  logic                             evt_valid_o;
  logic                             evt_ready_i;
  logic [CH_W-1:0]                  evt_chan_o;
  logic [warn_scan_pkg::CNT_W-1:0]  evt_cnt_o;

  modport master (output evt_valid_o, evt_chan_o, evt_cnt_o, input evt_ready_i);
  modport slave  (input evt_valid_o, evt_chan_o, evt_cnt_o, output evt_ready_i);
endinterface

// File: rtl/warn_evt_fifo.sv
// Synchronous show-ahead event FIFO; push is accepted when full if a pop
// happens in the same cycle. Data out holds the last popped head when empty.
module warn_evt_fifo
  import warn_scan_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = evt_w(8)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [AW:0]             count;
  logic [W-1:0]            last_head;
  logic                    do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? last_head : mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_head <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        last_head <= mem[rd_ptr];
      end
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage is never read while empty, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/warn_cnt_scan.sv
// Snapshots the per-channel warning counts and emits {channel, count} events
// for channels changed since their last report. WARN_SCAN_DELTA_EN: report delta.
module warn_cnt_scan
  import warn_scan_pkg::*;
#(
  parameter int TB_ARR     = 256,
  parameter int CH_W       = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [TB_ARR*CNT_W-1:0]  warnCnt_i,
  input  logic                     scan_start_i,
  input  logic                     scan_auto_i,
  output logic                     scan_busy_o,
  output logic                     scan_done_o,
  warn_cnt_scan_if.master          evt
);
  localparam int              EW       = evt_w(CH_W);
  localparam logic [CH_W-1:0] IDX_LAST = CH_W'(TB_ARR - 1);

  scan_state_e                   state, state_nxt;
  logic [CH_W-1:0]               idx;
  logic [TB_ARR-1:0][CNT_W-1:0]  snap, last;
  logic [CNT_W-1:0]              cur, prev, payload;
  logic                          changed, full, empty, pop, push, advance;
  logic [EW-1:0]                 head;

  assign cur     = snap[idx];
  assign prev    = last[idx];
  assign changed = (cur != prev);
  assign pop     = ~empty & evt.evt_ready_i;

`ifdef WARN_SCAN_DELTA_EN
  assign payload = cur - prev;
`else
  assign payload = cur;
`endif

  always_comb begin
    state_nxt   = state;
    push        = 1'b0;
    advance     = 1'b0;
    scan_busy_o = 1'b0;
    scan_done_o = 1'b0;
    case (state)
      IDLE: if (scan_start_i | scan_auto_i) state_nxt = SNAP;
      SNAP: begin
        scan_busy_o = 1'b1;
        state_nxt   = SCAN;
      end
      SCAN: begin
        scan_busy_o = 1'b1;
        // A changed channel waits in place until the FIFO can take it.
        if (changed) begin
          if (~full | pop) begin
            push    = 1'b1;
            advance = 1'b1;
          end
        end else begin
          advance = 1'b1;
        end
        if (advance && idx == IDX_LAST) state_nxt = DONE;
      end
      DONE: begin
        scan_busy_o = 1'b1;
        scan_done_o = 1'b1;
        state_nxt   = scan_auto_i ? SNAP : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx  <= '0;
      snap <= '0;
      last <= '0;
    end else begin
      if (state == SNAP) begin
        snap <= warnCnt_i;
        idx  <= '0;
      end
      if (push) last[idx] <= cur;
      if (advance) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  warn_evt_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .pop   (pop),
    .din   ({idx, payload}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign evt.evt_valid_o = ~empty;
  assign evt.evt_chan_o  = head[EW-1:CNT_W];
  assign evt.evt_cnt_o   = head[CNT_W-1:0];
endmodule
